// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and duty arithmetic for the RGB PWM fader
package pwm_pkg;
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  function automatic logic [31:0] cnt_max(input int dw);
    return (32'd1 << dw) - 32'd2;
  endfunction
  // One slew step from c toward t, clamped at t; operands are wider than any duty so nothing wraps
  function automatic logic [31:0] slew(input logic [31:0] c, input logic [31:0] t, input logic [31:0] step, input int dw);
    logic [31:0] s;
    s = step & ((32'd1 << dw) - 32'd1);
    s = (s == 32'd0) ? 32'd1 : s;
    return (t > c) ? ((c + s >= t) ? t : c + s) : ((c >= t + s) ? c - s : t);
  endfunction
endpackage

// File: rtl/rgb_pwm_fade_if.sv
// rgb_pwm_fade_if: valid/ready channel carrying new target duties
interface rgb_pwm_fade_if #(parameter int CH = 3, parameter int DW = 8);
  logic [CH*DW-1:0] duty_in;
  logic duty_valid;
  logic duty_ready;
  modport master(output duty_in, duty_valid, input duty_ready);
  modport slave(input duty_in, duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_fade_ch.sv
// pwm_fade_ch: one channel's active/shadow duty, slew or jump, and registered output
module pwm_fade_ch import pwm_pkg::*; #(
  parameter int DW = 8,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic          clk_pwm,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic          upd,
  input  logic          fade_en,
  input  logic [DW-1:0] duty,
  input  logic [DW-1:0] step,
  input  logic [DW-1:0] cnt,
  output logic          led,
  output logic          at_tgt
);
  logic [DW-1:0] cur, tgt, nxt;
  // next active duty at a boundary, and whether it lands on the target
  always_comb begin
    nxt = upd ? (fade_en ? DW'(slew(32'(cur), 32'(tgt), 32'(step), DW)) : tgt) : cur;
    at_tgt = nxt == tgt;
  end
  // duty registers and the compare output, forced inactive while disabled
  always_ff @(posedge clk_pwm)
    if (!rst_n) begin
      cur <= '0;
      tgt <= '0;
      led <= !ACTIVE_HIGH;
    end else begin
      cur <= nxt;
      if (load) tgt <= duty;
      led <= en ? ((cur > cnt) ~^ ACTIVE_HIGH) : !ACTIVE_HIGH;
    end
endmodule

// File: rtl/rgb_pwm_fade.sv
// rgb_pwm_fade: multi-channel PWM with prescaler, double-buffered duty update and linear fade
module rgb_pwm_fade import pwm_pkg::*; #(
  parameter int CH = 3,
  parameter int DW = 8,
  parameter int PRE_W = 8,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             clk_pwm,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic             fade_en,
  input  logic [DW-1:0]    fade_step,
  rgb_pwm_fade_if.slave    dif,
  output logic [CH-1:0]    led,
  output logic             period_end,
  output logic             fade_done
);
  localparam logic [DW-1:0] MAX = DW'(cnt_max(DW));
  logic [PRE_W-1:0] pc;
  logic [DW-1:0] cnt;
  logic pending, tick, boundary, accept, upd, done;
  logic [CH-1:0] at_tgt;
  assign tick = en && pc == prescale;
  assign boundary = tick && cnt == MAX;
  assign dif.duty_ready = rst_n && !pending;
  assign accept = dif.duty_valid && dif.duty_ready;
  assign upd = boundary && pending;
  assign done = upd && &at_tgt;
  // prescaler, period counter, pending flag and status pulses
  always_ff @(posedge clk_pwm)
    if (!rst_n) begin
      pc <= '0;
      cnt <= '0;
      pending <= 1'b0;
      period_end <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      pc <= tick ? '0 : en ? pc + 1'b1 : pc;
      cnt <= tick ? (cnt == MAX ? '0 : cnt + 1'b1) : cnt;
      pending <= accept || (pending && !done);
      period_end <= boundary;
      fade_done <= done;
    end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_fade_ch #(.DW(DW), .ACTIVE_HIGH(ACTIVE_HIGH)) u_ch (
      .clk_pwm, .rst_n, .en, .load(accept), .upd, .fade_en,
      .duty(dif.duty_in[i*DW +: DW]), .step(fade_step), .cnt,
      .led(led[i]), .at_tgt(at_tgt[i])
    );
  end
endmodule
